// File: rtl/spi_target.sv
// SPI mode-0 responder with a small register interface for TX/RX data and status.
// Define SPI_TARGET_RXFIFO_EN to replace the single RX data register with a 4-entry FIFO.
module spi_target #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cs,
    input  logic             i_sclk,
    input  logic             i_copi,
    output logic             o_cipo,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [3:0]       i_addr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t           r_state, w_state_next;
    logic             r_cs_s1, r_cs_s2, r_sclk_s1, r_sclk_s2, r_sclk_s3, r_copi_s1, r_copi_s2;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_tx_shift, r_rx_shift, r_tx_hold;
    logic             r_tx_full, r_ovf;
    logic             w_cs_act, w_sclk_rise, w_sclk_fall, w_push;
    logic             w_wr_do, w_wr_ov, w_rd, w_pop, w_ovf_set;
    logic             w_rx_empty, w_rx_full, w_rd_hit;
    logic [WIDTH-1:0] w_rx_word, w_rx_head, w_rd_val;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_copi_s1 <= 1'b1;
            r_copi_s2 <= 1'b1;
        end else begin
            r_cs_s1   <= i_cs;
            r_cs_s2   <= r_cs_s1;
            r_sclk_s1 <= i_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_copi_s1 <= i_copi;
            r_copi_s2 <= r_copi_s1;
        end
    end

    assign w_cs_act    = ~r_cs_s2;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    assign w_rx_word   = {r_rx_shift[WIDTH-2:0], r_copi_s2};
    assign o_cipo      = w_cs_act ? r_tx_shift[WIDTH-1] : 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_cs_act) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_sclk_rise && r_cnt == LAST_BIT) begin
                w_state_next = ST_LOAD;
                w_push       = w_cs_act;
            end
            default:  w_state_next = ST_IDLE;
        endcase
        if (!w_cs_act) w_state_next = ST_IDLE;
    end

    // The falling edge that trails the last rising edge of a frame lands after the
    // reload; gating on a non-zero count keeps the next frame's MSB in place.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_tx_shift <= ONES;
            r_rx_shift <= ONES;
        end else if (r_state == ST_LOAD) begin
            r_cnt      <= '0;
            r_tx_shift <= r_tx_full ? r_tx_hold : ONES;
        end else if (r_state == ST_SHIFT && w_cs_act) begin
            if (w_sclk_rise) begin
                r_rx_shift <= w_rx_word;
                r_cnt      <= r_cnt + 1'b1;
            end
            if (w_sclk_fall && r_cnt != '0)
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b1};
        end
    end

    assign w_wr_do = i_en & i_wr & (i_addr == 4'd1);
    assign w_wr_ov = i_en & i_wr & (i_addr == 4'd5);
    assign w_rd    = i_en & ~i_wr;
    assign w_pop   = w_rd & (i_addr == 4'd3) & ~w_rx_empty;

    // A write in the same cycle as LOAD wins: LOAD already sampled the old value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tx_hold <= '0;
            r_tx_full <= 1'b0;
        end else if (w_wr_do) begin
            r_tx_hold <= i_data;
            r_tx_full <= 1'b1;
        end else if (r_state == ST_LOAD) begin
            r_tx_full <= 1'b0;
        end
    end

`ifdef SPI_TARGET_RXFIFO_EN
    logic [WIDTH-1:0] r_fifo [4];
    logic [1:0]       r_wptr, r_rptr;
    logic [2:0]       r_count;
    logic             w_push_ok;

    assign w_rx_empty = (r_count == 3'd0);
    assign w_rx_full  = (r_count == 3'd4);
    assign w_rx_head  = r_fifo[r_rptr];
    assign w_push_ok  = w_push & (~w_rx_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_fifo[r_wptr] <= w_rx_word;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
        end
    end
`else
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_full;

    assign w_rx_empty = ~r_rx_full;
    assign w_rx_full  = r_rx_full;
    assign w_rx_head  = r_rx_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_data <= '0;
            r_rx_full <= 1'b0;
        end else if (w_push && (!r_rx_full || w_pop)) begin
            r_rx_data <= w_rx_word;
            r_rx_full <= 1'b1;
        end else if (w_pop) begin
            r_rx_full <= 1'b0;
        end
    end
`endif

    assign w_ovf_set = w_push & w_rx_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)       r_ovf <= 1'b0;
        else if (w_ovf_set) r_ovf <= 1'b1;
        else if (w_wr_ov)   r_ovf <= 1'b0;
    end

    always_comb begin
        w_rd_hit = 1'b1;
        w_rd_val = '0;
        case (i_addr)
            4'd0:    w_rd_val = {WIDTH{w_cs_act}};
            4'd2:    w_rd_val = {WIDTH{~r_tx_full}};
            4'd3:    w_rd_val = w_rx_empty ? '0 : w_rx_head;
            4'd4:    w_rd_val = {WIDTH{~w_rx_empty}};
            4'd5:    w_rd_val = {WIDTH{r_ovf}};
            default: w_rd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)              o_data <= '0;
        else if (w_rd && w_rd_hit) o_data <= w_rd_val;
    end
endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed scenarios plus random frames and
// register accesses, checked against a queue-based model of the register file.
module tb_spi_target;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_cs = 1'b1;
    logic       i_sclk = 1'b0;
    logic       i_copi = 1'b1;
    logic       i_en = 1'b0;
    logic       i_wr = 1'b0;
    logic [3:0] i_addr = 4'd0;
    logic [7:0] i_data = 8'd0;
    logic       o_cipo;
    logic [7:0] o_data;

    spi_target #(.WIDTH(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cs(i_cs), .i_sclk(i_sclk),
        .i_copi(i_copi), .o_cipo(o_cipo), .i_en(i_en), .i_wr(i_wr),
        .i_addr(i_addr), .i_data(i_data), .o_data(o_data)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass = 0;

`ifdef SPI_TARGET_RXFIFO_EN
    localparam int RX_CAP = 4;
`else
    localparam int RX_CAP = 1;
`endif

    // Model: TX holding slot, RX queue of bounded depth, overrun flag, last read.
    logic [7:0] m_hold = 8'h00;
    bit         m_full = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_q[$];
    logic [7:0] m_odata = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        m_hold = 8'h00;
        m_full = 1'b0;
        m_ovf = 1'b0;
        m_q.delete();
        m_odata = 8'h00;
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
        i_en = 1'b1; i_wr = 1'b1; i_addr = a; i_data = d;
        wait_clk(1);
        i_en = 1'b0; i_wr = 1'b0;
        if (a == 4'd1) begin m_hold = d; m_full = 1'b1; end
        if (a == 4'd5) m_ovf = 1'b0;
        $display("WR addr=%0d data=%02h", a, d);
    endtask

    task automatic reg_rd(input logic [3:0] a, input string tag);
        logic [7:0] exp;
        exp = m_odata;
        case (a)
            4'd0: exp = (i_cs == 1'b0) ? 8'hFF : 8'h00;
            4'd2: exp = m_full ? 8'h00 : 8'hFF;
            4'd3: exp = (m_q.size() > 0) ? m_q.pop_front() : 8'h00;
            4'd4: exp = (m_q.size() > 0) ? 8'hFF : 8'h00;
            4'd5: exp = m_ovf ? 8'hFF : 8'h00;
            default: ;
        endcase
        m_odata = exp;
        i_en = 1'b1; i_wr = 1'b0; i_addr = a;
        wait_clk(1);
        i_en = 1'b0;
        $display("RD addr=%0d data=%02h exp=%02h", a, o_data, exp);
        check(tag, o_data, exp);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_cs = 1'b1; i_sclk = 1'b0; i_copi = 1'b1;
        wait_clk(1);
        check("cipo_in_reset", o_cipo, 1'b1);
        wait_clk(1);
        i_rst_n = 1'b1;
        model_reset();
        wait_clk(4);
        $display("RESET");
    endtask

    // Clock nbits of d (MSB first); a short frame ends by CS release or by reset.
    task automatic run_frame(input logic [7:0] d, input int nbits, input bit rst_abort);
        logic [7:0] tx;
        tx = m_full ? m_hold : 8'hFF;
        m_full = 1'b0;
        i_cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            i_copi = d[7-i];
            wait_clk(5);
            check("cipo_bit", o_cipo, tx[7-i]);
            i_sclk = 1'b1;
            wait_clk(5);
            i_sclk = 1'b0;
        end
        i_copi = 1'b1;
        wait_clk(6);
        if (rst_abort) begin
            do_reset();
        end else begin
            i_cs = 1'b1;
            wait_clk(6);
            check("cipo_idle", o_cipo, 1'b1);
            if (nbits == 8) begin
                if (m_q.size() < RX_CAP) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        $display("FRAME copi=%02h bits=%0d tx=%02h", d, nbits, tx);
    endtask

    initial begin
        wait_clk(3);
        check("reset_cipo", o_cipo, 1'b1);
        check("reset_odata", o_data, 8'h00);
        i_rst_n = 1'b1;
        wait_clk(4);
        reg_rd(4'd0, "cs_idle");
        reg_rd(4'd2, "tr_reset");
        reg_rd(4'd4, "rr_reset");
        reg_rd(4'd5, "ov_reset");

        // DO!=A5 out while 3C comes in
        reg_wr(4'd1, 8'hA5);
        reg_rd(4'd2, "tr_full");
        run_frame(8'h3C, 8, 1'b0);
        reg_rd(4'd4, "rr_avail");
        reg_rd(4'd3, "di_3c");
        check("di_3c_const", o_data, 8'h3C);
        reg_rd(4'd4, "rr_empty");
        reg_rd(4'd3, "di_empty");

        // No DO! loaded: all-ones out
        run_frame(8'h00, 8, 1'b0);
        reg_rd(4'd2, "tr_empty");
        reg_rd(4'd3, "di_00");

        // Two frames without popping
        run_frame(8'h11, 8, 1'b0);
        run_frame(8'h22, 8, 1'b0);
        reg_rd(4'd5, "ov_two");
        reg_rd(4'd3, "di_first");
        check("di_first_const", o_data, 8'h11);
        reg_rd(4'd3, "di_second");
        reg_wr(4'd5, 8'h00);
        reg_rd(4'd5, "ov_clear");

        // Aborted partial frame then a complete one
        run_frame(8'h55, 5, 1'b0);
        run_frame(8'h81, 8, 1'b0);
        reg_rd(4'd4, "rr_one");
        reg_rd(4'd3, "di_81");
        reg_rd(4'd4, "rr_none");
        reg_rd(4'd5, "ov_partial");

        // Reset mid-frame, then a fresh frame
        reg_wr(4'd1, 8'hC3);
        run_frame(8'hAA, 3, 1'b1);
        reg_rd(4'd4, "rr_after_rst");
        reg_rd(4'd2, "tr_after_rst");
        run_frame(8'h7E, 8, 1'b0);
        reg_rd(4'd3, "di_7e");

        // Unmapped read keeps o_data; writes to read-only addresses ignored
        reg_rd(4'd9, "unmapped");
        reg_wr(4'd3, 8'h5A);
        reg_rd(4'd4, "ro_write");

        for (int it = 0; it < 30; it++) begin
            int nbits;
            if ($urandom_range(0, 1) == 1) reg_wr(4'd1, 8'($urandom));
            if ($urandom_range(0, 4) == 0) reg_wr(4'($urandom_range(0, 15)), 8'($urandom));
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            run_frame(8'($urandom), nbits, 1'b0);
            for (int r = 0; r < $urandom_range(0, 3); r++)
                reg_rd(4'($urandom_range(0, 7)), "rand_rd");
        end
        while (m_q.size() > 0) reg_rd(4'd3, "drain");
        reg_rd(4'd4, "rr_final");
        reg_rd(4'd5, "ov_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bus and SPI frame width in bits.
REQ-002 SHALL have port i_clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have ports i_cs (input, 1, SPI chip select, active-low), i_sclk (input, 1, SPI clock), i_copi (input, 1, controller-out data), o_cipo (output, 1, controller-in data).
REQ-005 SHALL have ports i_en (input, 1, device enable), i_wr (input, 1, 0:read 1:write), i_addr (input, 4, register select), i_data (input, WIDTH, write data), o_data (output, WIDTH, last data read).

Function
REQ-006 SHALL act as SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first, WIDTH bits per frame; i_sclk period SHALL be >= 8 i_clk periods.
REQ-007 SHALL pass i_cs, i_sclk, i_copi through 2-flop synchronizers; edges detected on synchronized values only.
REQ-008 Registers: 0 CS? read, all-ones if CS asserted else 0; 1 DO! write, load TX holding; 2 TR? read, all-ones if TX holding empty; 3 DI@ read, RX data and pop; 4 RR? read, all-ones if RX data available; 5 OV read, all-ones if overrun flag set; OV write clears flag.
REQ-009 o_data SHALL update one cycle after a read with i_en=1, i_wr=0; SHALL hold otherwise; unmapped read addresses leave o_data unchanged; writes to read-only addresses ignored.
REQ-010 FSM states IDLE (CS deasserted), LOAD (one cycle), SHIFT; IDLE->LOAD on CS assert; LOAD->SHIFT; SHIFT->LOAD after WIDTH-th rising sclk; any state->IDLE on CS deassert.
REQ-011 In LOAD: TX shift register loaded from TX holding (holding marked empty), or all-ones if holding empty; bit counter cleared.
REQ-012 In SHIFT: synchronized rising sclk shifts i_copi into RX shift LSB and increments counter; falling sclk shifts TX shift left by one.
REQ-013 o_cipo SHALL equal TX shift MSB while CS asserted, 1 while deasserted.
REQ-014 On WIDTH-th rising sclk: RX shift value pushed to RX storage; if storage full, value dropped and overrun flag set.
REQ-015 CS deassert mid-frame SHALL discard partial RX bits and SHALL not push; TX holding unaffected unless already consumed in LOAD.
REQ-016 DO! write while TX holding full SHALL overwrite; DO! write in same cycle as LOAD consumption: LOAD takes old value, new value remains in holding, flagged full.
REQ-017 DI@ read when RX empty SHALL return 0 and not change state; simultaneous pop and push SHALL both take effect with no overrun.

Reset
REQ-018 While i_rst_n=0 at a clock edge: FSM IDLE, counter 0, shift registers all-ones, TX holding empty, RX storage empty, overrun clear, o_data 0, o_cipo 1, synchronizers loaded with idle values (cs=1, sclk=0, copi=1).
REQ-019 Reset mid-frame SHALL abandon the frame; responder resyncs on next CS assertion after reset release.

Configuration
REQ-020 Macro SPI_TARGET_RXFIFO_EN: defined, RX storage is 4-entry FIFO, with wrap-around pointers; RR? all-ones when non-empty; overrun when push with 4 entries held.
REQ-021 Macro not defined: RX storage is single register; overrun on push while register full; all other behaviour identical.

Verification
REQ-022 Write DO!=0xA5, assert CS, clock frame copi=0x3C -> o_cipo bits 1,0,1,0,0,1,0,1; RR? reads 0xFF; DI@ reads 0x3C; RR? then 0x00.
REQ-023 No DO! write, one frame copi=0x00 -> o_cipo all 1 for all 8 bits; TR? reads 0xFF throughout.
REQ-024 Two frames 0x11, 0x22 without DI@ read -> without macro: OV reads 0xFF, DI@ reads 0x11; with macro: OV 0x00, DI@ returns 0x11 then 0x22.
REQ-025 Deassert CS after 5 sclk edges, then full frame 0x81 -> exactly one RX entry, value 0x81, OV 0x00.
REQ-026 Assert i_rst_n=0 after bit 3 of a frame, release, new frame 0x7E -> RR? 0x00 before new frame, DI@ 0x7E after; o_cipo 1 during reset.
